// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment pattern table and output polarity helpers
package seg7_pkg;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, SEG_OFF, SEG_OFF,
    SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF
  };
  function automatic logic [6:0] seg_drive(input logic [6:0] pat, input logic active_low);
    return active_low ? ~pat : pat;
  endfunction
  function automatic logic bit_drive(input logic b, input logic active_low);
    return b ^ active_low;
  endfunction
endpackage

// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: control, data and pin bundle of the scanned display
interface bcd_scan_display_if #(parameter int N_DIGITS = 4);
  logic                  ena;
  logic                  load;
  logic [4*N_DIGITS-1:0] bcd_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  lz_blank;
  logic [2:0]            bright;
  logic                  disp_en;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   dig_sel;
  modport master (
    output ena, load, bcd_in, dp_in, lz_blank, bright, disp_en,
    input  seg, dp, dig_sel
  );
  modport slave (
    input  ena, load, bcd_in, dp_in, lz_blank, bright, disp_en,
    output seg, dp, dig_sel
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to {a..g} pattern, non-decimal codes dark
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pat
);
  assign pat = SEG_TABLE[bcd];
endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed BCD seven-segment driver with blanking and dimming
module bcd_scan_display
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIV_WIDTH      = 10,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input logic              clk,
  input logic              rst_n,
  bcd_scan_display_if.slave bus
);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic SA = SEG_ACTIVE_LOW != 0;
  localparam logic DA = DIG_ACTIVE_LOW != 0;
  localparam logic [6:0] SEG_IDLE = seg_drive(SEG_OFF, SA);
  localparam logic [N_DIGITS-1:0] DIG_IDLE = {N_DIGITS{DA}};
  logic [DIV_WIDTH-1:0]  presc;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] sh_bcd;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   lz;
  logic                  tick;
  logic                  lit;
  logic                  blank;
  logic [3:0]            cur;
  logic [6:0]            pat;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [N_DIGITS-1:0]   dig_n;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [N_DIGITS-1:0]   dig_q;
  assign tick = bus.ena && (&presc);
  assign cur  = sh_bcd[idx*4 +: 4];
  seg7_decode u_dec (
    .bcd(cur),
    .pat(pat)
  );
  // lz[i]: every shadow digit from the top down to i is zero; digit 0 is never suppressed
  always_comb begin
    lz = '0;
    lz[N_DIGITS-1] = sh_bcd[4*N_DIGITS-1 -: 4] == 4'd0;
    for (int i = N_DIGITS - 2; i >= 1; i--) lz[i] = lz[i+1] && (sh_bcd[4*i +: 4] == 4'd0);
  end
  assign blank = bus.lz_blank && lz[idx];
  assign lit   = bus.disp_en && (presc[DIV_WIDTH-1 -: 3] <= bus.bright);
  assign seg_n = seg_drive((lit && !blank) ? pat : SEG_OFF, SA);
  assign dp_n  = bit_drive(lit && sh_dp[idx], SA);
  assign dig_n = (lit ? (N_DIGITS'(1) << idx) : '0) ^ DIG_IDLE;
  // prescaler, scan index and shadow capture; load and tick may share an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      idx    <= '0;
      sh_bcd <= '0;
      sh_dp  <= '0;
    end else begin
      if (bus.ena) presc <= presc + 1'b1;
      if (tick) idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (bus.load) begin
        sh_bcd <= bus.bcd_in;
        sh_dp  <= bus.dp_in;
      end
    end
  end
  // pin registers at final polarity; frozen together with the scan when ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_IDLE;
      dp_q  <= SA;
      dig_q <= DIG_IDLE;
    end else if (bus.ena) begin
      seg_q <= seg_n;
      dp_q  <= dp_n;
      dig_q <= dig_n;
    end
  end
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
  assign bus.dig_sel = dig_q;
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed vector table plus timing corner sequences
module tb_bcd_scan_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bcd_scan_display_if #(.N_DIGITS(4)) bus ();
  bcd_scan_display_if #(.N_DIGITS(4)) bus2 ();
  bcd_scan_display #(.N_DIGITS(4), .DIV_WIDTH(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  bcd_scan_display #(.N_DIGITS(4), .DIV_WIDTH(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  assign bus2.ena      = bus.ena;
  assign bus2.load     = bus.load;
  assign bus2.bcd_in   = bus.bcd_in;
  assign bus2.dp_in    = bus.dp_in;
  assign bus2.lz_blank = bus.lz_blank;
  assign bus2.bright   = bus.bright;
  assign bus2.disp_en  = bus.disp_en;
  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
    logic        lz;
    logic [2:0]  br;
    logic        de;
    int          k;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;
  } vec_t;
  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void add(input logic [15:0] b, input logic [3:0] d, input logic lz,
                              input logic [2:0] br, input logic de, input int k,
                              input logic [6:0] s, input logic p, input logic [3:0] g);
    vec_t v;
    v.bcd = b; v.dpv = d; v.lz = lz; v.br = br; v.de = de; v.k = k;
    v.seg = s; v.dp = p; v.dig = g;
    vecs.push_back(v);
  endfunction
  // reset, then load on edge 1; returns just after edge 1
  task automatic restart(input logic [15:0] bcd, input logic [3:0] dpv, input logic lz,
                         input logic [2:0] br, input logic de);
    rst_n = 1'b0;
    bus.load = 1'b0; bus.ena = 1'b1; bus.bcd_in = bcd; bus.dp_in = dpv;
    bus.lz_blank = lz; bus.bright = br; bus.disp_en = de;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  initial begin
    int bad;
    int cnt;
    int ovl;
    logic [6:0] sl;
    logic [3:0] dl;
    add(16'h1234, 4'b0000, 0, 7, 1,  2, 7'b0110011, 0, 4'b0001);
    add(16'h1234, 4'b0000, 0, 7, 1, 17, 7'b1111001, 0, 4'b0010);
    add(16'h1234, 4'b0000, 0, 7, 1, 33, 7'b1101101, 0, 4'b0100);
    add(16'h1234, 4'b0000, 0, 7, 1, 64, 7'b0110000, 0, 4'b1000);
    add(16'h1234, 4'b0000, 1, 7, 1, 64, 7'b0110000, 0, 4'b1000);
    add(16'h0050, 4'b0000, 1, 7, 1, 64, 7'b0000000, 0, 4'b1000);
    add(16'h0050, 4'b0000, 1, 7, 1, 40, 7'b0000000, 0, 4'b0100);
    add(16'h0050, 4'b0000, 1, 7, 1, 20, 7'b1011011, 0, 4'b0010);
    add(16'h0050, 4'b0000, 1, 7, 1,  5, 7'b1111110, 0, 4'b0001);
    add(16'h0050, 4'b0000, 0, 7, 1, 50, 7'b1111110, 0, 4'b1000);
    add(16'h0050, 4'b0000, 0, 7, 1, 36, 7'b1111110, 0, 4'b0100);
    add(16'h1234, 4'b0000, 0, 0, 1,  2, 7'b0110011, 0, 4'b0001);
    add(16'h1234, 4'b0000, 0, 0, 1,  3, 7'b0000000, 0, 4'b0000);
    add(16'h1234, 4'b0000, 0, 3, 1,  8, 7'b0110011, 0, 4'b0001);
    add(16'h1234, 4'b0000, 0, 3, 1,  9, 7'b0000000, 0, 4'b0000);
    add(16'h1234, 4'b0001, 0, 0, 1,  5, 7'b0000000, 0, 4'b0000);
    add(16'h1234, 4'b0100, 0, 7, 1, 35, 7'b1101101, 1, 4'b0100);
    add(16'h0050, 4'b1000, 1, 7, 1, 60, 7'b0000000, 1, 4'b1000);
    add(16'hAF00, 4'b0000, 0, 7, 1, 60, 7'b0000000, 0, 4'b1000);
    add(16'hAF00, 4'b0000, 0, 7, 1, 40, 7'b0000000, 0, 4'b0100);
    add(16'hAF00, 4'b0000, 1, 7, 1, 30, 7'b1111110, 0, 4'b0010);
    add(16'h1234, 4'b1111, 0, 7, 0, 20, 7'b0000000, 0, 4'b0000);
    add(16'h9876, 4'b0000, 0, 7, 1, 10, 7'b1011111, 0, 4'b0001);
    add(16'h9876, 4'b0000, 0, 7, 1, 18, 7'b1110000, 0, 4'b0010);
    add(16'h9876, 4'b0000, 0, 7, 1, 35, 7'b1111111, 0, 4'b0100);
    add(16'h9876, 4'b0000, 0, 7, 1, 50, 7'b1111011, 0, 4'b1000);
    rst_n = 1'b0;
    bus.load = 1'b0; bus.ena = 1'b1; bus.bcd_in = 16'h1234; bus.dp_in = 4'hf;
    bus.lz_blank = 1'b0; bus.bright = 3'd7; bus.disp_en = 1'b1;
    @(negedge clk);
    check("reset seg", 16'(bus.seg), 16'h0000);
    check("reset dp", 16'(bus.dp), 16'h0000);
    check("reset dig", 16'(bus.dig_sel), 16'h0000);
    check("reset seg al", 16'(bus2.seg), 16'h007f);
    check("reset dp al", 16'(bus2.dp), 16'h0001);
    check("reset dig al", 16'(bus2.dig_sel), 16'h000f);
    rst_n = 1'b1;
    @(negedge clk);
    check("first edge seg", 16'(bus.seg), 16'h007e);
    check("first edge dig", 16'(bus.dig_sel), 16'h0001);
    @(negedge clk);
    check("second edge seg", 16'(bus.seg), 16'h007e);
    for (int i = 0; i < vecs.size(); i++) begin
      restart(vecs[i].bcd, vecs[i].dpv, vecs[i].lz, vecs[i].br, vecs[i].de);
      repeat (vecs[i].k - 1) @(negedge clk);
      sl = ~vecs[i].seg;
      dl = ~vecs[i].dig;
      check($sformatf("vec%0d seg", i), 16'(bus.seg), 16'(vecs[i].seg));
      check($sformatf("vec%0d dp", i), 16'(bus.dp), 16'(vecs[i].dp));
      check($sformatf("vec%0d dig", i), 16'(bus.dig_sel), 16'(vecs[i].dig));
      check($sformatf("vec%0d seg al", i), 16'(bus2.seg), 16'(sl));
      check($sformatf("vec%0d dig al", i), 16'(bus2.dig_sel), 16'(dl));
    end
    for (int b = 0; b < 3; b++) begin
      restart(16'h1234, 4'b0000, 0, (b == 0) ? 3'd0 : (b == 1) ? 3'd3 : 3'd7, 1);
      cnt = 0;
      ovl = 0;
      repeat (64) begin
        @(negedge clk);
        if (bus.dig_sel != 4'b0000) cnt++;
        if ($countones(bus.dig_sel) > 1) ovl++;
      end
      check($sformatf("duty b%0d lit cycles", b), 16'(cnt), (b == 0) ? 16'd8 : (b == 1) ? 16'd32 : 16'd64);
      check($sformatf("duty b%0d onehot", b), 16'(ovl), 16'd0);
    end
    restart(16'h1234, 4'b0000, 0, 7, 1);
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.seg != 7'b0110011 || bus.dig_sel != 4'b0001) bad++;
    end
    check("slot0 stable", 16'(bad), 16'd0);
    bus.load = 1'b1;
    bus.bcd_in = 16'h9999;
    @(negedge clk);
    bus.load = 1'b0;
    check("tick load old seg", 16'(bus.seg), 16'h0033);
    check("tick load old dig", 16'(bus.dig_sel), 16'h0001);
    @(negedge clk);
    check("tick load new seg", 16'(bus.seg), 16'h007b);
    check("tick load new dig", 16'(bus.dig_sel), 16'h0002);
    restart(16'h1234, 4'b0000, 0, 7, 1);
    repeat (4) @(negedge clk);
    check("pre reset seg", 16'(bus.seg), 16'h0033);
    #2 rst_n = 1'b0;
    #1;
    check("async reset seg", 16'(bus.seg), 16'h0000);
    check("async reset dig", 16'(bus.dig_sel), 16'h0000);
    check("async reset seg al", 16'(bus2.seg), 16'h007f);
    check("async reset dig al", 16'(bus2.dig_sel), 16'h000f);
    restart(16'hAF00, 4'b0000, 0, 7, 1);
    repeat (19) @(negedge clk);
    check("freeze pre seg", 16'(bus.seg), 16'h007e);
    check("freeze pre dig", 16'(bus.dig_sel), 16'h0002);
    bus.ena = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.seg != 7'b1111110 || bus.dig_sel != 4'b0010 || bus.dp != 1'b0) bad++;
    end
    check("freeze hold", 16'(bad), 16'd0);
    bus.ena = 1'b1;
    @(negedge clk);
    check("resume seg", 16'(bus.seg), 16'h007e);
    check("resume dig", 16'(bus.dig_sel), 16'h0002);
    repeat (12) @(negedge clk);
    check("resume next slot seg", 16'(bus.seg), 16'h0000);
    check("resume next slot dig", 16'(bus.dig_sel), 16'h0004);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV_WIDTH, default 10: refresh prescaler width, minimum 4; one digit slot lasts 2^DIV_WIDTH clk cycles.
REQ-003 Parameter SEG_ACTIVE_LOW, default 0: 1 inverts seg and dp at the output pins.
REQ-004 Parameter DIG_ACTIVE_LOW, default 0: 1 inverts dig_sel at the output pins.
REQ-005 clk  input  1  single system clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 ena  input  1  count enable; low freezes prescaler and scan index, outputs hold.
REQ-008 load  input  1  one-cycle strobe; captures bcd_in and dp_in into the shadow register.
REQ-009 bcd_in  input  4*N_DIGITS  packed BCD digits, digit 0 (least significant) in bits [3:0].
REQ-010 dp_in  input  N_DIGITS  decimal-point request per digit.
REQ-011 lz_blank  input  1  leading-zero suppression enable.
REQ-012 bright  input  3  duty level 0..7.
REQ-013 disp_en  input  1  global display enable; low blanks all segments and digits.
REQ-014 seg  output  7  segment drive {a,b,c,d,e,f,g}, a = MSB, registered.
REQ-015 dp  output  1  decimal-point drive, registered.
REQ-016 dig_sel  output  N_DIGITS  one-hot digit select, registered.

Function
REQ-017 Prescaler: DIV_WIDTH-bit up-counter, increments when ena=1, wraps from 2^DIV_WIDTH-1 to 0; the wrap cycle is the scan tick.
REQ-018 Scan index: increments on scan tick, wraps from N_DIGITS-1 to 0.
REQ-019 Shadow register: updated on the clk edge where load=1; seg/dp/dig_sel read only the shadow, never bcd_in/dp_in directly.
REQ-020 Decode: 0-9 map to standard patterns (0=1111110, 1=0110000, 8=1111111, 9=1111011); codes A-F decode to all segments off.
REQ-021 Leading-zero suppression: when lz_blank=1, digit i (i>=1) is blanked if shadow digits N_DIGITS-1 down to i are all 0; digit 0 is never suppressed; dp of a suppressed digit remains driven per dp_in.
REQ-022 Duty: within a slot, the active digit is lit when prescaler[DIV_WIDTH-1:DIV_WIDTH-3] <= bright; bright=7 gives 100%, bright=0 gives 1/8.
REQ-023 Unlit slot portion or disp_en=0: seg, dp and dig_sel all at inactive levels.
REQ-024 Outputs register the decode of the current index/prescaler/shadow; latency exactly one clk from those state values.
REQ-025 load coincident with scan tick: both take effect on the same edge; new shadow data appears one clk later on the new index.
REQ-026 dig_sel SHALL never have more than one active bit in any cycle.
REQ-027 ena=0 mid-slot: outputs hold their last values until ena returns.

Reset
REQ-028 rst_n low: prescaler=0, index=0, shadow digits=0, shadow dp=0, seg/dp/dig_sel at inactive levels (respecting polarity parameters), effective immediately.
REQ-029 First rising clk after rst_n deassert with ena=1, disp_en=1: prescaler=1; next edge drives digit 0 showing "0".

Structure
REQ-030 Segment pattern constants and polarity helpers SHALL live in shared package seg7_pkg.
REQ-031 BCD-to-pattern decode SHALL be a combinational sub-module seg7_decode instantiated once (on the muxed digit).

Verification (N_DIGITS=4, DIV_WIDTH=4, polarities 0 unless stated)
REQ-032 load bcd_in=16'h1234, bright=7 -> over 64 cycles dig_sel cycles 0001,0010,0100,1000, each held 16 cycles; seg = 0110011, 1111001, 1101101, 0110000.
REQ-033 load 16'h0050, lz_blank=1 -> digits 3,2 seg=0000000; digit 1 = 1011011; digit 0 = 1111110; lz_blank=0 -> digits 3,2 show 1111110.
REQ-034 bright=0 -> dig_sel active 2 of 16 cycles per slot; bright=3 -> 8 of 16.
REQ-035 load asserted on the tick cycle with 16'h9999 while showing 16'h1234 -> no output mixes data mid-slot; new slot shows 1111011.
REQ-036 rst_n pulsed low mid-slot -> outputs inactive same cycle; SEG_ACTIVE_LOW=1 run -> seg reset value 1111111.
REQ-037 load bcd_in=16'hAF00 -> digits 3,2 blank; ena=0 for 20 cycles -> outputs constant.
